// File: rtl/ddr_sched_pkg.sv
// Shared types and constants for the DDR4 in-order command scheduler:
// command/kind/state encodings, address-field positions, bank entry layout.
package ddr_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_PRE = 3'd2,
    CMD_RD  = 3'd3,
    CMD_WR  = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    KIND_HIT      = 2'd0,
    KIND_CLOSED   = 2'd1,
    KIND_CONFLICT = 2'd2
  } kind_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_PRE       = 3'd2,
    ST_WAIT_RP   = 3'd3,
    ST_ACT       = 3'd4,
    ST_WAIT_RCD  = 3'd5,
    ST_CAS       = 3'd6,
    ST_WAIT_DATA = 3'd7
  } state_e;

  localparam int ADDR_W  = 33;
  localparam int ROW_MSB = 32;
  localparam int ROW_LSB = 18;
  localparam int COL_MSB = 17;
  localparam int COL_LSB = 10;
  localparam int BA_MSB  = 9;
  localparam int BA_LSB  = 8;
  localparam int BG_MSB  = 7;
  localparam int BG_LSB  = 6;

  localparam int ROW_W  = 15;
  localparam int COL_W  = 8;
  localparam int RAS_W  = 8;
  localparam int WAIT_W = 8;
  localparam int NBANKS = 16;

  localparam logic [1:0] OP_READ   = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_IFETCH = 2'd2;

  localparam int DEF_T_RCD   = 24;
  localparam int DEF_T_RP    = 24;
  localparam int DEF_T_CL    = 24;
  localparam int DEF_T_CWL   = 20;
  localparam int DEF_T_BURST = 4;
  localparam int DEF_T_RAS   = 52;

  typedef struct packed {
    logic             open;
    logic [ROW_W-1:0] row;
    logic [RAS_W-1:0] ras_cnt;
  } bank_entry_t;

  function automatic logic [3:0] bank_idx(input logic [1:0] bg, input logic [1:0] ba);
    return {bg, ba};
  endfunction

endpackage

// File: rtl/ddr_bank_table.sv
// Per-bank open-row state for all 16 banks, with a free-running tRAS
// countdown per bank that keeps ticking regardless of scheduler state.
module ddr_bank_table
  import ddr_sched_pkg::*;
#(
  parameter int T_RAS = DEF_T_RAS
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [3:0]       i_rd_idx,
  output bank_entry_t      o_rd_entry,
  input  logic             i_set,
  input  logic             i_clr,
  input  logic [3:0]       i_wr_idx,
  input  logic [ROW_W-1:0] i_wr_row
);

  bank_entry_t r_banks [NBANKS];

  // An ACT reloads the tRAS window; every other bank just counts toward zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NBANKS; i++) begin
        r_banks[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBANKS; i++) begin
        if (i_set && (i_wr_idx == 4'(i))) begin
          r_banks[i].open    <= 1'b1;
          r_banks[i].row     <= i_wr_row;
          r_banks[i].ras_cnt <= RAS_W'(T_RAS - 1);
        end else begin
          if (i_clr && (i_wr_idx == 4'(i))) begin
            r_banks[i].open <= 1'b0;
          end
          if (r_banks[i].ras_cnt != '0) begin
            r_banks[i].ras_cnt <= r_banks[i].ras_cnt - 1'b1;
          end
        end
      end
    end
  end

  assign o_rd_entry = r_banks[i_rd_idx];

endmodule

// File: rtl/ddr_cmd_sched.sv
// In-order DDR4 command scheduler: takes one queue-head request at a time and
// sequences PRE/ACT/RD/WR under an open-page policy, then pulses done.
module ddr_cmd_sched
  import ddr_sched_pkg::*;
#(
  parameter int T_RCD   = DEF_T_RCD,
  parameter int T_RP    = DEF_T_RP,
  parameter int T_CL    = DEF_T_CL,
  parameter int T_CWL   = DEF_T_CWL,
  parameter int T_BURST = DEF_T_BURST,
  parameter int T_RAS   = DEF_T_RAS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_op,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              o_cmd_valid,
  output cmd_e              o_cmd,
  output logic [1:0]        o_cmd_bg,
  output logic [1:0]        o_cmd_ba,
  output logic [ROW_W-1:0]  o_cmd_row,
  output logic [COL_W-1:0]  o_cmd_col,
  output logic              o_done_valid,
  output logic [1:0]        o_done_op,
  output kind_e             o_done_kind
);

  state_e             r_state;
  state_e             w_next_state;
  logic [1:0]         r_op;
  logic [1:0]         r_bg;
  logic [1:0]         r_ba;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  kind_e              r_kind;
  logic [WAIT_W-1:0]  r_wait_cnt;

  bank_entry_t        w_entry;
  kind_e              w_kind;
  logic [3:0]         w_bank_idx;
  logic               w_bank_set;
  logic               w_bank_clr;
  logic               w_pre_fire;
  logic               w_wait_done;
  logic               w_is_write;
  logic               w_unused;

  assign w_bank_idx  = bank_idx(r_bg, r_ba);
  assign w_pre_fire  = (r_state == ST_PRE) && (w_entry.ras_cnt == '0);
  assign w_wait_done = (r_wait_cnt == '0);
  assign w_is_write  = (r_op == OP_WRITE);
  assign w_kind      = !w_entry.open           ? KIND_CLOSED :
                       (w_entry.row == r_row)  ? KIND_HIT    : KIND_CONFLICT;
  assign w_unused    = ^i_req_addr[BG_LSB-1:0];

  ddr_bank_table #(.T_RAS(T_RAS)) u_bank_table (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rd_idx   (w_bank_idx),
    .o_rd_entry (w_entry),
    .i_set      (w_bank_set),
    .i_clr      (w_bank_clr),
    .i_wr_idx   (w_bank_idx),
    .i_wr_row   (r_row)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op   <= '0;
      r_bg   <= '0;
      r_ba   <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_kind <= KIND_HIT;
    end else begin
      if ((r_state == ST_IDLE) && i_req_valid) begin
        r_op  <= i_req_op;
        r_row <= i_req_addr[ROW_MSB:ROW_LSB];
        r_col <= i_req_addr[COL_MSB:COL_LSB];
        r_ba  <= i_req_addr[BA_MSB:BA_LSB];
        r_bg  <= i_req_addr[BG_MSB:BG_LSB];
      end
      if (r_state == ST_DECODE) begin
        r_kind <= w_kind;
      end
    end
  end

  // Each wait state is entered one cycle after its issuing command, so the
  // load value is the gap minus the issue cycle and the final zero cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ST_PRE: begin
          if (w_pre_fire) begin
            r_wait_cnt <= WAIT_W'(T_RP - 2);
          end
        end
        ST_ACT:  r_wait_cnt <= WAIT_W'(T_RCD - 2);
        ST_CAS:  r_wait_cnt <= w_is_write ? WAIT_W'(T_CWL + T_BURST - 1)
                                          : WAIT_W'(T_CL + T_BURST - 1);
        ST_WAIT_RP, ST_WAIT_RCD, ST_WAIT_DATA: begin
          if (!w_wait_done) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      if (i_req_valid) w_next_state = ST_DECODE;
      ST_DECODE: begin
        case (w_kind)
          KIND_HIT:    w_next_state = ST_CAS;
          KIND_CLOSED: w_next_state = ST_ACT;
          default:     w_next_state = ST_PRE;
        endcase
      end
      ST_PRE:       if (w_pre_fire) w_next_state = ST_WAIT_RP;
      ST_WAIT_RP:   if (w_wait_done) w_next_state = ST_ACT;
      ST_ACT:       w_next_state = ST_WAIT_RCD;
      ST_WAIT_RCD:  if (w_wait_done) w_next_state = ST_CAS;
      ST_CAS:       w_next_state = ST_WAIT_DATA;
      ST_WAIT_DATA: if (w_wait_done) w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  // Reset forces every output quiet, even while the state is still mid-request.
  always_comb begin
    o_req_ready  = 1'b0;
    o_cmd_valid  = 1'b0;
    o_cmd        = CMD_NOP;
    o_cmd_bg     = '0;
    o_cmd_ba     = '0;
    o_cmd_row    = '0;
    o_cmd_col    = '0;
    o_done_valid = 1'b0;
    o_done_op    = '0;
    o_done_kind  = KIND_HIT;
    w_bank_set   = 1'b0;
    w_bank_clr   = 1'b0;
    if (!i_rst) begin
      case (r_state)
        ST_IDLE: o_req_ready = 1'b1;
        ST_PRE: begin
          if (w_pre_fire) begin
            o_cmd_valid = 1'b1;
            o_cmd       = CMD_PRE;
            w_bank_clr  = 1'b1;
          end
        end
        ST_ACT: begin
          o_cmd_valid = 1'b1;
          o_cmd       = CMD_ACT;
          w_bank_set  = 1'b1;
        end
        ST_CAS: begin
          o_cmd_valid = 1'b1;
          o_cmd       = w_is_write ? CMD_WR : CMD_RD;
        end
        ST_WAIT_DATA: begin
          if (w_wait_done) begin
            o_done_valid = 1'b1;
            o_done_op    = r_op;
            o_done_kind  = r_kind;
          end
        end
        default: ;
      endcase
      if (o_cmd_valid) begin
        o_cmd_bg  = r_bg;
        o_cmd_ba  = r_ba;
        o_cmd_row = r_row;
        o_cmd_col = r_col;
      end
    end
  end

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Scoreboard bench for ddr_cmd_sched: a cycle-level timing model predicts every
// command and retire pulse at accept time; a monitor compares what the DUT emits.
module tb_ddr_cmd_sched;
  import ddr_sched_pkg::*;

  localparam int TRCD = 24, TRP = 24, TCL = 24, TCWL = 20, TBURST = 4, TRAS = 52;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [1:0]  reqOp = '0;
  logic [32:0] reqAddr = '0;
  logic        cmdValid;
  cmd_e        cmdOut;
  logic [1:0]  cmdBg, cmdBa;
  logic [14:0] cmdRow;
  logic [7:0]  cmdCol;
  logic        doneValid;
  logic [1:0]  doneOp;
  kind_e       doneKind;

  ddr_cmd_sched #(
    .T_RCD(TRCD), .T_RP(TRP), .T_CL(TCL), .T_CWL(TCWL), .T_BURST(TBURST), .T_RAS(TRAS)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(reqValid), .o_req_ready(reqReady), .i_req_op(reqOp), .i_req_addr(reqAddr),
    .o_cmd_valid(cmdValid), .o_cmd(cmdOut), .o_cmd_bg(cmdBg), .o_cmd_ba(cmdBa),
    .o_cmd_row(cmdRow), .o_cmd_col(cmdCol),
    .o_done_valid(doneValid), .o_done_op(doneOp), .o_done_kind(doneKind)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint      cyc;
    cmd_e        cmd;
    logic [3:0]  bank;
    logic [14:0] field;
  } expCmd_t;

  typedef struct {
    longint     cyc;
    logic [1:0] op;
    int         kind;
  } expDone_t;

  expCmd_t  cmdQ[$];
  expDone_t doneQ[$];
  expCmd_t  mc;
  expDone_t md;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  longint busyLo = 1, busyHi = 0, modelFree = 0, lastAct = 0, lastDone = 0;

  bit          modelOpen  [16];
  logic [14:0] modelRow   [16];
  longint      modelActAt [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  function automatic void pushCmd(input longint c, input cmd_e k, input logic [3:0] b,
                                  input logic [14:0] f);
    expCmd_t e;
    e.cyc = c; e.cmd = k; e.bank = b; e.field = f;
    cmdQ.push_back(e);
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 16; i++) begin
      modelOpen[i]  = 1'b0;
      modelRow[i]   = '0;
      modelActAt[i] = -1000000;
    end
    cmdQ.delete();
    doneQ.delete();
    busyLo = 1; busyHi = 0; modelFree = 0;
  endfunction

  // Spec-level timing: each command lands at a fixed offset from the accept cycle.
  function automatic void modelAccept(input longint a, input logic [1:0] op, input logic [32:0] addr);
    logic [14:0] row;
    logic [7:0]  col;
    logic [3:0]  idx;
    longint      act, pre, cas, done;
    int          kind;
    expDone_t    d;
    row = addr[32:18];
    col = addr[17:10];
    idx = {addr[7:6], addr[9:8]};
    act = 0;
    if (modelOpen[idx] && modelRow[idx] == row) begin
      kind = 0;
      cas  = a + 2;
    end else begin
      if (!modelOpen[idx]) begin
        kind = 1;
        act  = a + 2;
      end else begin
        kind = 2;
        pre  = (a + 2 > modelActAt[idx] + TRAS) ? a + 2 : modelActAt[idx] + TRAS;
        pushCmd(pre, CMD_PRE, idx, '0);
        act  = pre + TRP;
      end
      pushCmd(act, CMD_ACT, idx, row);
      modelOpen[idx]  = 1'b1;
      modelRow[idx]   = row;
      modelActAt[idx] = act;
      lastAct         = act;
      cas             = act + TRCD;
    end
    pushCmd(cas, (op == 2'd1) ? CMD_WR : CMD_RD, idx, {7'd0, col});
    done = cas + ((op == 2'd1) ? TCWL : TCL) + TBURST;
    d.cyc = done; d.op = op; d.kind = kind;
    doneQ.push_back(d);
    busyLo = a + 1; busyHi = done; modelFree = done + 1; lastDone = done;
  endfunction

  task automatic applyStimulus(input logic [1:0] op, input logic [32:0] addr, input bit hold);
    longint predA;
    int     n;
    if (!reqValid) begin
      @(posedge clk); #1;
    end
    reqOp = op; reqAddr = addr; reqValid = 1'b1;
    predA = (cyc > modelFree) ? cyc : modelFree;
    n = 0;
    @(negedge clk);
    while (!reqReady && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (!reqReady) begin
      errors++; checks++;
      $display("[TB] FAIL accept_timeout at cycle %0d: got req_ready 0, expected 1", cyc);
      reqValid = 1'b0;
      return;
    end
    checkOutput("accept_cycle", cyc, predA);
    modelAccept(predA, op, addr);
    @(posedge clk); #1;
    if (!hold) reqValid = 1'b0;
  endtask

  task automatic waitUntil(input longint target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a command or done.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_outputs",
                  longint'({reqReady, cmdValid, cmdOut, cmdBg, cmdBa, cmdRow, cmdCol,
                            doneValid, doneOp, doneKind}), 0);
    end else begin
      checkOutput("req_ready", longint'(reqReady),
                  longint'(!(cyc >= busyLo && cyc <= busyHi)));
      while (cmdQ.size() > 0 && cmdQ[0].cyc < cyc) begin
        mc = cmdQ.pop_front();
        errors++; checks++;
        $display("[TB] FAIL cmd_missing at cycle %0d: got nothing, expected cmd %0d at cycle %0d",
                 cyc, mc.cmd, mc.cyc);
      end
      if (cmdValid) begin
        if (cmdQ.size() == 0) begin
          errors++; checks++;
          $display("[TB] FAIL cmd_unexpected at cycle %0d: got cmd %0d, expected no command",
                   cyc, cmdOut);
        end else begin
          mc = cmdQ.pop_front();
          checkOutput("cmd_cycle", cyc, mc.cyc);
          checkOutput("cmd_type", longint'(cmdOut), longint'(mc.cmd));
          checkOutput("cmd_bank", longint'({cmdBg, cmdBa}), longint'(mc.bank));
          if (mc.cmd == CMD_ACT)
            checkOutput("cmd_row", longint'(cmdRow), longint'(mc.field));
          else if (mc.cmd == CMD_RD || mc.cmd == CMD_WR)
            checkOutput("cmd_col", longint'(cmdCol), longint'(mc.field));
        end
      end else begin
        checkOutput("cmd_nop", longint'(cmdOut), longint'(CMD_NOP));
      end
      while (doneQ.size() > 0 && doneQ[0].cyc < cyc) begin
        md = doneQ.pop_front();
        errors++; checks++;
        $display("[TB] FAIL done_missing at cycle %0d: got nothing, expected done at cycle %0d",
                 cyc, md.cyc);
      end
      if (doneValid) begin
        if (doneQ.size() == 0) begin
          errors++; checks++;
          $display("[TB] FAIL done_unexpected at cycle %0d: got done op %0d, expected none",
                   cyc, doneOp);
        end else begin
          md = doneQ.pop_front();
          checkOutput("done_cycle", cyc, md.cyc);
          checkOutput("done_op", longint'(doneOp), longint'(md.op));
          checkOutput("done_kind", longint'(doneKind), longint'(md.kind));
        end
      end
    end
  end

  initial begin
    logic [14:0] rRow;
    logic [7:0]  rCol;
    logic [1:0]  rBa, rBg, rOp;
    logic [5:0]  rOff;
    int          gap;
    modelReset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(2'd0, 33'h0_0000_0000, 1'b0);
    applyStimulus(2'd0, 33'h0_0000_0400, 1'b1);
    applyStimulus(2'd1, 33'h0_0004_0000, 1'b0);
    applyStimulus(2'd2, 33'h0_0000_00C0, 1'b0);
    applyStimulus(2'd0, 33'h0_0004_0000, 1'b0);
    // Conflict right after a write to a fresh bank: PRE must wait out tRAS.
    applyStimulus(2'd1, 33'h0_0000_0200, 1'b1);
    applyStimulus(2'd0, 33'h0_0004_0200, 1'b0);

    applyStimulus(2'd0, 33'h0_0000_0100, 1'b0);
    waitUntil(lastAct + 3);
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(2'd0, 33'h0_0000_0100, 1'b0);
    applyStimulus(2'd0, 33'h0_0004_0000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      gap = int'($urandom_range(0, 4));
      repeat (gap) begin
        @(posedge clk); #1;
      end
      rOp  = 2'($urandom_range(0, 2));
      rRow = 15'($urandom_range(0, 2));
      rCol = 8'($urandom_range(0, 255));
      rBa  = 2'($urandom_range(0, 1));
      rBg  = 2'($urandom_range(0, 1));
      rOff = 6'($urandom_range(0, 63));
      applyStimulus(rOp, {rRow, rCol, rBa, rBg, rOff}, 1'($urandom_range(0, 1)));
    end
    reqValid = 1'b0;

    waitUntil(lastDone + 5);
    checkOutput("scoreboard_drained", longint'(cmdQ.size() + doneQ.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
